imem_loader: RTL and testbench

Program-load writer for the instruction memory's load port (en / in). It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words to sequential word addresses and checks a trailing 32-bit sum. The core is held in reset until a verified image has been loaded; the top level muxes load_addr onto the instruction-memory word address while core_rst_n is low.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_asm.sv | 46 ++++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// imem_loader_pkg : state encoding and shared constants for the program loader
// Revision: 1.0
// ============================================================================
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Bytes per header word, data word and trailer word.
  localparam int unsigned C_HDR_BYTES = 4;

  // Default instruction-memory word-address width (depth 2^12 words).
  localparam int unsigned C_IMEM_ADDR_W = 12;

endpackage
`default_nettype wire

// File: rtl/imem_loader_asm.sv
`default_nettype none
// ============================================================================
// imem_loader_asm : little-endian byte-to-word assembler with completion strobe
// Revision: 1.0
// ============================================================================
module imem_loader_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  localparam logic [1:0] C_LAST_IDX = 2'(C_HDR_BYTES - 1);

  logic [1:0]  r_idx;
  logic [23:0] r_asm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
      r_asm <= 24'd0;
    end else if (i_clear) begin
      r_idx <= 2'd0;
      r_asm <= 24'd0;
    end else if (i_accept) begin
      case (r_idx)
        2'd0:    r_asm[7:0]   <= i_byte;
        2'd1:    r_asm[15:8]  <= i_byte;
        2'd2:    r_asm[23:16] <= i_byte;
        default: ;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

  // The top byte bypasses storage so the full word is usable on its final accept.
  assign o_word      = {i_byte, r_asm};
  assign o_word_done = i_accept && (r_idx == C_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : streams a checksummed image into instruction memory, then
//               releases the core from reset once the image is verified
// Revision: 1.0
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = C_IMEM_ADDR_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_load_en,
  output logic [31:0]       o_load_data,
  output logic [ADDR_W-1:0] o_load_addr,
  output logic              o_core_rst_n,
  output logic              o_done,
  output logic              o_error
);

  localparam int unsigned       C_TMO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]       C_MAX_WORDS = 32'd1 << ADDR_W;

  state_t              r_state;
  logic [ADDR_W:0]     r_widx;
  logic [31:0]         r_n;
  logic [31:0]         r_sum;
  logic [C_TMO_W-1:0]  r_tmo;
  logic                r_load_en;
  logic [31:0]         r_load_data;
  logic [ADDR_W-1:0]   r_load_addr;
  logic                r_core_rst_n;
  logic                r_done;
  logic                r_error;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_restart;
  logic [31:0]         w_word;
  logic                w_word_done;
  logic [ADDR_W:0]     w_widx_nxt;

  assign w_in_ready = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_restart  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_widx_nxt = r_widx + (ADDR_W + 1)'(1);

  imem_loader_asm u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_restart),
    .i_accept    (w_accept),
    .i_byte      (i_in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_widx       <= '0;
      r_n          <= 32'd0;
      r_sum        <= 32'd0;
      r_tmo        <= '0;
      r_load_en    <= 1'b0;
      r_load_data  <= 32'd0;
      r_load_addr  <= '0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_load_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state      <= S_HDR;
            r_widx       <= '0;
            r_sum        <= 32'd0;
            r_tmo        <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
          end
        end
        S_HDR, S_DATA, S_CHK: begin
          r_tmo <= w_accept ? '0 : r_tmo + C_TMO_W'(1);
          if (!w_accept && (r_tmo == C_TMO_LAST)) begin
            // A partially assembled word is dropped; restart clears the assembler.
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else if (w_word_done) begin
            case (r_state)
              S_HDR: begin
                r_n <= w_word;
                if (w_word > C_MAX_WORDS) begin
                  r_state <= S_ERR;
                  r_error <= 1'b1;
                end else if (w_word == 32'd0) begin
                  r_state <= S_CHK;
                end else begin
                  r_state <= S_DATA;
                end
              end
              S_DATA: begin
                r_load_en   <= 1'b1;
                r_load_data <= w_word;
                r_load_addr <= r_widx[ADDR_W-1:0];
                r_widx      <= w_widx_nxt;
                r_sum       <= r_sum + w_word;
                if (32'(w_widx_nxt) == r_n) r_state <= S_CHK;
              end
              default: begin
                if (w_word == r_sum) begin
                  r_state      <= S_DONE;
                  r_done       <= 1'b1;
                  r_core_rst_n <= 1'b1;
                end else begin
                  r_state <= S_ERR;
                  r_error <= 1'b1;
                end
              end
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_load_en    = r_load_en;
  assign o_load_data  = r_load_data;
  assign o_load_addr  = r_load_addr;
  assign o_core_rst_n = r_core_rst_n;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : randomized self-checking bench for imem_loader
// Revision: 1.0
// ============================================================================
module tb_imem_loader;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic              i_in_valid;
  logic [7:0]        i_in_data;
  logic              o_in_ready;
  logic              o_load_en;
  logic [31:0]       o_load_data;
  logic [ADDR_W-1:0] o_load_addr;
  logic              o_core_rst_n;
  logic              o_done;
  logic              o_error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0]       img[$];
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                wq_cyc[$];

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_load_en    (o_load_en),
    .o_load_data  (o_load_data),
    .o_load_addr  (o_load_addr),
    .o_core_rst_n (o_core_rst_n),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write seen by the instruction memory.
  always @(negedge clk) begin
    if (o_load_en === 1'b1) begin
      wq_addr.push_back(o_load_addr);
      wq_data.push_back(o_load_data);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_min, input int gap_max);
    int gap;
    gap = $urandom_range(gap_max, gap_min);
    i_in_valid = 1'b0;
    repeat (gap) tick();
    n_checks++;
    if (o_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL in_ready_while_loading: got %b want 1", o_in_ready);
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_min, input int gap_max);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_min, gap_max);
  endtask

  // Streams header, img[0..n-1] and trailer, then checks writes and outcome
  // against what the image format dictates.
  task automatic run_image(input logic [31:0] n_hdr, input logic [31:0] trailer,
                           input int gap_min, input int gap_max, input string tag);
    logic [31:0] exp_sum;
    logic        exp_ok;
    int          exp_writes;
    clear_writes();
    pulse_start();
    send_word(n_hdr, gap_min, gap_max);
    if (n_hdr <= (32'd1 << ADDR_W)) begin
      for (int i = 0; i < int'(n_hdr); i++) send_word(img[i], gap_min, gap_max);
      send_word(trailer, gap_min, gap_max);
    end
    tick();
    tick();
    exp_sum = 32'd0;
    exp_writes = 0;
    if (n_hdr <= (32'd1 << ADDR_W)) begin
      exp_writes = int'(n_hdr);
      for (int i = 0; i < exp_writes; i++) exp_sum = exp_sum + img[i];
    end
    exp_ok = (n_hdr <= (32'd1 << ADDR_W)) && (trailer == exp_sum);
    n_checks++;
    if (wq_addr.size() != exp_writes) begin
      n_errors++;
      $display("FAIL %s write_count: got %0d want %0d", tag, wq_addr.size(), exp_writes);
    end else begin
      for (int i = 0; i < exp_writes; i++) begin
        n_checks++;
        if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== img[i]) begin
          n_errors++;
          $display("FAIL %s write%0d: got addr=%h data=%h want addr=%h data=%h",
                   tag, i, wq_addr[i], wq_data[i], ADDR_W'(i), img[i]);
        end
      end
    end
    n_checks++;
    if (o_done !== exp_ok || o_error !== !exp_ok || o_core_rst_n !== exp_ok) begin
      n_errors++;
      $display("FAIL %s outcome: got done=%b error=%b core_rst_n=%b want done=%b error=%b core_rst_n=%b",
               tag, o_done, o_error, o_core_rst_n, exp_ok, !exp_ok, exp_ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({o_in_ready, o_load_en, o_load_data, o_load_addr, o_core_rst_n, o_done, o_error} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got ready=%b en=%b data=%h addr=%h core_rst_n=%b done=%b error=%b want all 0",
               o_in_ready, o_load_en, o_load_data, o_load_addr, o_core_rst_n, o_done, o_error);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (o_in_ready !== 1'b0 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got ready=%b done=%b want 0 0", o_in_ready, o_done);
    end
  endtask

  task automatic test_nominal();
    img = '{32'h0000_0013, 32'h00A0_0093};
    run_image(32'd2, 32'h00A0_00A6, 0, 0, "nominal");
  endtask

  task automatic test_bad_sum();
    img = '{32'h0000_0013, 32'h00A0_0093};
    run_image(32'd2, 32'h0000_0000, 0, 2, "bad_sum");
  endtask

  task automatic test_oversize();
    img.delete();
    run_image(32'h0000_1001, 32'd0, 0, 0, "oversize");
    n_checks++;
    if (o_in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL oversize_ready: got %b want 0", o_in_ready);
    end
  endtask

  task automatic test_timeout();
    clear_writes();
    pulse_start();
    send_word(32'd2, 0, 0);
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    repeat (TIMEOUT - 1) tick();
    n_checks++;
    if (o_error !== 1'b0 || o_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_early: got error=%b ready=%b want 0 1", o_error, o_in_ready);
    end
    tick();
    n_checks++;
    if (o_error !== 1'b1 || o_in_ready !== 1'b0 || o_core_rst_n !== 1'b0 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_abort: got error=%b ready=%b core_rst_n=%b done=%b want 1 0 0 0",
               o_error, o_in_ready, o_core_rst_n, o_done);
    end
    tick();
    n_checks++;
    if (wq_addr.size() != 0) begin
      n_errors++;
      $display("FAIL timeout_writes: got %0d want 0", wq_addr.size());
    end
  endtask

  task automatic test_restart_zero();
    img.delete();
    run_image(32'd0, 32'd0, 0, 0, "zero_len");
    pulse_start();
    n_checks++;
    if (o_core_rst_n !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0 || o_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL restart_from_done: got core_rst_n=%b done=%b error=%b ready=%b want 0 0 0 1",
               o_core_rst_n, o_done, o_error, o_in_ready);
    end
    repeat (TIMEOUT + 2) tick();
  endtask

  task automatic test_slow_gaps();
    img = '{32'hCAFE_F00D};
    run_image(32'd1, 32'hCAFE_F00D, TIMEOUT - 2, TIMEOUT - 2, "gap14");
  endtask

  task automatic test_back_to_back();
    img = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    run_image(32'd4, 32'hAAAA_AAAA, 0, 0, "back_to_back");
    for (int i = 1; i < wq_cyc.size(); i++) begin
      n_checks++;
      if (wq_cyc[i] - wq_cyc[i-1] != 4) begin
        n_errors++;
        $display("FAIL b2b_spacing%0d: got %0d cycles want 4", i, wq_cyc[i] - wq_cyc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] n;
    logic [31:0] s;
    logic [31:0] trailer;
    for (int it = 0; it < 6; it++) begin
      n = 32'($urandom_range(8, 1));
      img.delete();
      s = 32'd0;
      for (int i = 0; i < int'(n); i++) begin
        img.push_back($urandom);
        s = s + img[i];
      end
      trailer = ($urandom_range(1, 0) == 1) ? s : (s ^ ($urandom | 32'd1));
      run_image(n, trailer, 0, TIMEOUT - 2, $sformatf("random%0d", it));
    end
  endtask

  task automatic test_async_reset();
    clear_writes();
    pulse_start();
    send_word(32'd3, 0, 0);
    send_word(32'hDEAD_BEEF, 0, 0);
    send_byte(8'h5A, 0, 0);
    send_byte(8'hA5, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_in_ready, o_load_en, o_load_data, o_load_addr, o_core_rst_n, o_done, o_error} !== '0) begin
      n_errors++;
      $display("FAIL async_reset_outputs: got ready=%b en=%b data=%h addr=%h core_rst_n=%b done=%b error=%b want all 0",
               o_in_ready, o_load_en, o_load_data, o_load_addr, o_core_rst_n, o_done, o_error);
    end
    #3;
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (o_in_ready !== 1'b0 || o_load_en !== 1'b0 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle: got ready=%b en=%b done=%b want 0 0 0", o_in_ready, o_load_en, o_done);
    end
    n_checks++;
    if (wq_addr.size() != 1 || wq_data[0] !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL async_reset_writes: got count=%0d want 1 (DEADBEEF only)", wq_addr.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    i_in_data  = 8'h00;
    test_reset();
    test_nominal();
    test_bad_sum();
    test_oversize();
    test_timeout();
    test_restart_zero();
    test_slow_gaps();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
